// File: rtl/systolic_array_ctrl.sv
//======================================================================
// Module   : systolic_array_ctrl
// Brief    : Job sequencer for a systolic_array: operand feed with
//            diagonal skew, zero flush, done pulse and result capture.
//            Optional perf counters are built when SA_CTRL_PERF_EN is defined.
// Revision : 1.0 - initial release
//======================================================================
`default_nettype none

module systolic_array_ctrl #(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int K_BITS     = 8,
    parameter int PE_LAT     = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [K_BITS-1:0]                     k_len,
    output logic                                  busy,
    input  logic                                  op_valid,
    output logic                                  op_ready,
    input  logic [ARR_HEIGHT*WIDTH-1:0]           op_a,
    input  logic [ARR_WIDTH*WIDTH-1:0]            op_b,
    output logic [ARR_HEIGHT*WIDTH-1:0]           sa_in_a,
    output logic [ARR_WIDTH*WIDTH-1:0]            sa_in_b,
    output logic                                  sa_done,
    input  logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0] sa_out_c,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0] res_c
`ifdef SA_CTRL_PERF_EN
    ,
    output logic [31:0]                           perf_cycles,
    output logic [31:0]                           perf_bubbles
`endif
);

    localparam int c_flush_cycles = ARR_HEIGHT + ARR_WIDTH - 1 + PE_LAT;
    localparam int c_flush_w      = $clog2(ARR_HEIGHT + ARR_WIDTH + PE_LAT);
    localparam logic [c_flush_w-1:0] c_flush_last = c_flush_w'(c_flush_cycles - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_FLUSH   = 3'd2,
        S_DONE    = 3'd3,
        S_CAPTURE = 3'd4,
        S_RESULT  = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [K_BITS-1:0]       r_k_len;
    logic [K_BITS-1:0]       r_beat_cnt;
    logic [c_flush_w-1:0]    r_flush_cnt;
    logic                    w_start_ok;
    logic                    w_accept;
    logic                    w_last_beat;
    logic [ARR_HEIGHT*WIDTH-1:0] w_feed_a;
    logic [ARR_WIDTH*WIDTH-1:0]  w_feed_b;

    assign w_start_ok  = (r_state == S_IDLE) && start && (k_len != '0);
    assign w_accept    = (r_state == S_FEED) && op_valid;
    assign w_last_beat = w_accept && (r_beat_cnt == (r_k_len - K_BITS'(1)));

    // Non-accepting cycles inject zeros on both edges so bubbles add nothing.
    assign w_feed_a = w_accept ? op_a : '0;
    assign w_feed_b = w_accept ? op_b : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        op_ready    = 1'b0;
        sa_done     = 1'b0;
        res_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_start_ok) w_state_nxt = S_FEED;
            end
            S_FEED: begin
                op_ready = 1'b1;
                if (w_last_beat) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (r_flush_cnt == c_flush_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                sa_done     = 1'b1;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_nxt = S_RESULT;
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_start_ok) begin
                r_k_len    <= k_len;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + K_BITS'(1);
            end
            if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + c_flush_w'(1);
            end else begin
                r_flush_cnt <= '0;
            end
        end
    end

    // Row lane i: i skew stages plus the shared output register.
    for (genvar gi = 0; gi < ARR_HEIGHT; gi++) begin : g_skew_a
        logic [WIDTH-1:0] r_pipe [gi+1];
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s <= gi; s++) r_pipe[s] <= '0;
            end else begin
                r_pipe[0] <= w_feed_a[gi*WIDTH +: WIDTH];
                for (int s = 1; s <= gi; s++) r_pipe[s] <= r_pipe[s-1];
            end
        end
        assign sa_in_a[gi*WIDTH +: WIDTH] = r_pipe[gi];
    end

    for (genvar gj = 0; gj < ARR_WIDTH; gj++) begin : g_skew_b
        logic [WIDTH-1:0] r_pipe [gj+1];
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s <= gj; s++) r_pipe[s] <= '0;
            end else begin
                r_pipe[0] <= w_feed_b[gj*WIDTH +: WIDTH];
                for (int s = 1; s <= gj; s++) r_pipe[s] <= r_pipe[s-1];
            end
        end
        assign sa_in_b[gj*WIDTH +: WIDTH] = r_pipe[gj];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_c <= '0;
        end else if (r_state == S_CAPTURE) begin
            res_c <= sa_out_c;
        end
    end

`ifdef SA_CTRL_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_bubbles;

    // Cycles are counted over FEED and FLUSH, i.e. from FEED entry until DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_cycles  <= '0;
            r_perf_bubbles <= '0;
        end else if (w_start_ok) begin
            r_perf_cycles  <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if ((r_state == S_FEED) || (r_state == S_FLUSH)) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if ((r_state == S_FEED) && !op_valid) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
        end
    end

    assign perf_cycles  = r_perf_cycles;
    assign perf_bubbles = r_perf_bubbles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_array_ctrl.sv
//======================================================================
// Module   : tb_systolic_array_ctrl
// Brief    : Self-checking bench for systolic_array_ctrl with a
//            behavioural array, matrix-product reference and skew monitor.
// Revision : 1.0 - initial release
//======================================================================
`default_nettype none

module tb_systolic_array_ctrl;

    localparam int WIDTH = 16;
    localparam int H     = 4;
    localparam int W     = 4;
    localparam int KB    = 8;
    localparam int PE    = 2;
    localparam int CW    = H*W*WIDTH;
    localparam int HMAX  = 8192;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [KB-1:0]     k_len = '0;
    logic              op_valid = 1'b0;
    logic [H*WIDTH-1:0] op_a = '0;
    logic [W*WIDTH-1:0] op_b = '0;
    logic              res_ready = 1'b0;
    logic [CW-1:0]     sa_out_c;
    logic              busy, op_ready, sa_done, res_valid;
    logic [H*WIDTH-1:0] sa_in_a;
    logic [W*WIDTH-1:0] sa_in_b;
    logic [CW-1:0]     res_c;
`ifdef SA_CTRL_PERF_EN
    logic [31:0]       perf_cycles, perf_bubbles;
`endif

    int ncmp = 0;
    int nfail = 0;

    systolic_array_ctrl #(
        .WIDTH(WIDTH), .ARR_HEIGHT(H), .ARR_WIDTH(W), .K_BITS(KB), .PE_LAT(PE)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .k_len(k_len), .busy(busy),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .sa_in_a(sa_in_a), .sa_in_b(sa_in_b), .sa_done(sa_done),
        .sa_out_c(sa_out_c), .res_valid(res_valid), .res_ready(res_ready),
        .res_c(res_c)
`ifdef SA_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_bubbles(perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural output-stationary array: a moves east, b moves south.
    logic [WIDTH-1:0] pa [H][W];
    logic [WIDTH-1:0] pb [H][W];
    logic [WIDTH-1:0] acc [H][W];

    function automatic logic [WIDTH-1:0] a_at(int i, int j);
        return (j == 0) ? sa_in_a[i*WIDTH +: WIDTH] : pa[i][j-1];
    endfunction

    function automatic logic [WIDTH-1:0] b_at(int i, int j);
        return (i == 0) ? sa_in_b[j*WIDTH +: WIDTH] : pb[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < W; j++) begin
                if (!busy) begin
                    acc[i][j] <= '0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end else if (res_valid) begin
                    acc[i][j] <= acc[i][j] + WIDTH'(1);
                end else begin
                    acc[i][j] <= acc[i][j] + a_at(i, j) * b_at(i, j);
                    pa[i][j]  <= a_at(i, j);
                    pb[i][j]  <= b_at(i, j);
                end
            end
        end
    end

    always_comb begin
        sa_out_c = '0;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++)
                sa_out_c[(i*W+j)*WIDTH +: WIDTH] = acc[i][j];
    end

    // Skew monitor: beat fed in cycle t must show on lane n at t+1+n.
    logic [H*WIDTH-1:0] hist_a [HMAX];
    logic [W*WIDTH-1:0] hist_b [HMAX];
    int  gcyc = 0;
    int  hist_base = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) begin
        if (gcyc < HMAX) begin
            hist_a[gcyc] <= (op_valid && op_ready) ? op_a : '0;
            hist_b[gcyc] <= (op_valid && op_ready) ? op_b : '0;
        end
        gcyc <= gcyc + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < H; i++) begin
                int idx;
                idx = gcyc - 1 - i;
                chk("skew_a", sa_in_a[i*WIDTH +: WIDTH],
                    (idx >= hist_base) ? hist_a[idx][i*WIDTH +: WIDTH] : '0);
            end
            for (int j = 0; j < W; j++) begin
                int idx;
                idx = gcyc - 1 - j;
                chk("skew_b", sa_in_b[j*WIDTH +: WIDTH],
                    (idx >= hist_base) ? hist_b[idx][j*WIDTH +: WIDTH] : '0);
            end
        end
    end

    // Entry: just after a rising edge in IDLE. Exit: same.
    // mode 0 = random data, 1 = identity A / scaled B, 2 = skew pattern.
    task automatic run_job(input int k, input logic [31:0] mask, input int mode,
                           input int exp_lat, input int hold);
        bit vq[$];
        longint ec [H][W];
        logic [CW-1:0] exp_c, exp_b, got_c;
        int cyc, nb, beat, lat, ndone, done_cyc, t0a, t3a, elat, av;
        nb = 0; beat = 0; lat = -1; ndone = 0; done_cyc = -1; t0a = -1; t3a = -1;
        for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) ec[i][j] = 0;
        for (int n = 0; n < k; n++) begin
            if (mask[n]) begin vq.push_back(1'b0); nb++; end
            vq.push_back(1'b1);
        end
        elat = (exp_lat >= 0) ? exp_lat : k + H + W + PE + 2 + nb;

        start = 1'b1; k_len = KB'(k);
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        for (int c = 0; c < vq.size(); c++) begin
            op_valid = vq[c];
            for (int i = 0; i < H; i++) begin
                av = (mode == 1) ? ((i == beat) ? 1 : 0) : (mode == 2) ? i + 1 : int'($urandom);
                if (!vq[c]) av = int'($urandom);
                op_a[i*WIDTH +: WIDTH] = WIDTH'(av);
            end
            for (int j = 0; j < W; j++) begin
                av = (mode == 1) ? (j + 1) * (beat + 1) : (mode == 2) ? j + 1 : int'($urandom);
                if (!vq[c]) av = int'($urandom);
                op_b[j*WIDTH +: WIDTH] = WIDTH'(av);
            end
            @(negedge clk);
            chk("op_ready_feed", op_ready, 1);
            if (vq[c]) begin
                for (int i = 0; i < H; i++)
                    for (int j = 0; j < W; j++)
                        ec[i][j] = (ec[i][j] + longint'(op_a[i*WIDTH +: WIDTH]) *
                                    longint'(op_b[j*WIDTH +: WIDTH])) & 64'hFFFF;
                beat++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        op_valid = 1'b0; op_a = '0; op_b = '0;

        for (int c = 0; c < 200 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 0) chk("op_ready_drop", op_ready, 0);
            if (sa_done) begin ndone++; done_cyc = cyc; end
            if (mode == 2) begin
                if (t0a < 0 && sa_in_a[0 +: WIDTH] == WIDTH'(1)) t0a = cyc;
                if (t3a < 0 && sa_in_a[3*WIDTH +: WIDTH] == WIDTH'(4)) t3a = cyc;
            end
            if (res_valid) lat = cyc;
            else begin @(posedge clk); #1; cyc++; end
        end
        if (lat < 0) begin
            chk("res_valid_timeout", 0, 1);
            return;
        end
        chk("res_latency", lat, elat);
        chk("sa_done_count", ndone, 1);
        chk("sa_done_cycle", done_cyc, elat - 2);
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) begin
                exp_c[(i*W+j)*WIDTH +: WIDTH] = WIDTH'(ec[i][j]);
                exp_b[(i*W+j)*WIDTH +: WIDTH] = WIDTH'((j + 1) * (i + 1));
            end
        chk("res_c", res_c, exp_c);
        if (mode == 1) chk("res_c_ident", res_c, exp_b);
        if (mode == 2) begin
            chk("skew_lane0_cycle", t0a, 2);
            chk("skew_lane3_delta", t3a - t0a, 3);
        end
`ifdef SA_CTRL_PERF_EN
        chk("perf_bubbles", perf_bubbles, nb);
        chk("perf_cycles", perf_cycles, k + nb + H + W - 1 + PE);
`endif
        got_c = res_c;

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            start = h[0]; k_len = KB'(3);
            @(negedge clk);
            chk("hold_res_valid", res_valid, 1);
            chk("hold_res_c", res_c, got_c);
            chk("hold_busy", busy, 1);
        end
        @(posedge clk); #1;
        res_ready = 1'b1; start = 1'b1; k_len = KB'(3);
        @(negedge clk);
        chk("hs_res_valid", res_valid, 1);
        @(posedge clk); #1;
        res_ready = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post_hs_busy", busy, 0);
        chk("post_hs_res_valid", res_valid, 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          k;
        logic [31:0] mask;
        int          mode;
        int          exp_lat;
        int          hold;
    } job_t;

    job_t tbl [5];

    initial begin
        tbl[0] = '{4, 32'h0,   1, 16, 0};
        tbl[1] = '{4, 32'ha,   1, 18, 10};
        tbl[2] = '{1, 32'h0,   2, 13, 0};
        tbl[3] = '{9, 32'h121, 0, 24, 1};
        tbl[4] = '{2, 32'h3,   0, 16, 2};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_sa_done", sa_done, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_c", res_c, 0);
        chk("rst_sa_in_a", sa_in_a, 0);
        chk("rst_sa_in_b", sa_in_b, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        start = 1'b1; k_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("k0_busy", busy, 0);
        chk("k0_op_ready", op_ready, 0);
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++)
            run_job(tbl[t].k, tbl[t].mask, tbl[t].mode, tbl[t].exp_lat, tbl[t].hold);

        // Reset in the middle of FEED after two of four beats.
        start = 1'b1; k_len = KB'(4);
        @(posedge clk); #1;
        start = 1'b0; op_valid = 1'b1;
        op_a = {H{16'h1234}}; op_b = {W{16'h0042}};
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; hist_base = gcyc; op_valid = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_op_ready", op_ready, 0);
        chk("midrst_sa_done", sa_done, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_res_c", res_c, 0);
        chk("midrst_sa_in_a", sa_in_a, 0);
        chk("midrst_sa_in_b", sa_in_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(1, 32'h0, 0, 13, 0);

        for (int r = 0; r < 12; r++) begin
            int          k;
            logic [31:0] m;
            k = int'($urandom_range(1, 20));
            m = $urandom & ((32'h1 << k) - 32'h1);
            run_job(k, m, 0, -1, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
